alu_op_sequencer: RTL

Control-side counterpart of the 8-bit relay ALU. It decodes an ALU-class instruction byte (1000 R FFF) and drives the 3-bit function code to the ALU. It then waits a programmable relay-settle interval and captures alu_result into destination register A (R=0) or D (R=1). In the same cycle it latches the sign/carry/zero condition register. It sits between the instruction register/sequencer and the ALU, and owns the A, D and condition registers.

---
 rtl/alu_op_sequencer_if.sv | 32 +++
 rtl/alu_op_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// Bus bundle between the instruction sequencer/ALU side and alu_op_sequencer.
// The slave modport is the sequencer's view; master is the driving environment.
interface alu_op_sequencer_if;
    logic       start;
    logic [7:0] instr;
    logic [7:0] alu_result;
    logic       sign;
    logic       carry;
    logic       zero;
    logic [2:0] fctn_code;
    logic       alu_enable;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] reg_a;
    logic [7:0] reg_d;
    logic       cond_sign;
    logic       cond_carry;
    logic       cond_zero;

    modport slave (
        input  start, instr, alu_result, sign, carry, zero,
        output fctn_code, alu_enable, busy, done, err,
               reg_a, reg_d, cond_sign, cond_carry, cond_zero
    );

    modport master (
        output start, instr, alu_result, sign, carry, zero,
        input  fctn_code, alu_enable, busy, done, err,
               reg_a, reg_d, cond_sign, cond_carry, cond_zero
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Decodes ALU-class instructions (1000 R FFF), drives the relay ALU, waits for it to
// settle and captures result/flags. Optional: ALU_SEQ_NULL_NOWRITE_EN (NULL fn skips write).
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic               clk,
    input  logic               reset,
    alu_op_sequencer_if.slave  bus
);
    localparam int unsigned CNT_W   = 4;
    localparam logic [3:0]  OPC_ALU = 4'b1000;
    localparam logic [2:0]  FN_ADD  = 3'b000;
    localparam logic [2:0]  FN_INC  = 3'b001;
    localparam logic [2:0]  FN_SHL  = 3'b110;
    localparam logic [2:0]  FN_NULL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_LATCH,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [3:0]         r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_fctn;
    logic               r_alu_en;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [7:0]         r_reg_a;
    logic [7:0]         r_reg_d;
    logic               r_cond_sign;
    logic               r_cond_carry;
    logic               r_cond_zero;

    logic               w_is_alu;
    logic               w_carry_fn;
    logic               w_write_en;

    assign w_is_alu   = (bus.instr[7:4] == OPC_ALU);
    // Only the arithmetic functions produce a meaningful carry.
    assign w_carry_fn = (r_op[2:0] == FN_ADD) || (r_op[2:0] == FN_INC) ||
                        (r_op[2:0] == FN_SHL);

`ifdef ALU_SEQ_NULL_NOWRITE_EN
    assign w_write_en = (r_op[2:0] != FN_NULL);
`else
    assign w_write_en = 1'b1;
`endif

    // Sequencer FSM with registered outputs and architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_cnt        <= '0;
            r_fctn       <= '0;
            r_alu_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_reg_a      <= '0;
            r_reg_d      <= '0;
            r_cond_sign  <= 1'b0;
            r_cond_carry <= 1'b0;
            r_cond_zero  <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_is_alu) begin
                            r_op     <= bus.instr[3:0];
                            r_fctn   <= bus.instr[2:0];
                            r_alu_en <= 1'b1;
                            r_busy   <= 1'b1;
                            r_cnt    <= CNT_W'(SETTLE_CYCLES - 1);
                            r_state  <= S_SETTLE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= S_LATCH;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_LATCH: begin
                    if (w_write_en) begin
                        if (r_op[3]) begin
                            r_reg_d <= bus.alu_result;
                        end else begin
                            r_reg_a <= bus.alu_result;
                        end
                    end
                    r_cond_sign  <= bus.sign;
                    r_cond_zero  <= bus.zero;
                    r_cond_carry <= w_carry_fn ? bus.carry : 1'b0;
                    r_alu_en     <= 1'b0;
                    r_done       <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_fctn  <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fctn_code  = r_fctn;
    assign bus.alu_enable = r_alu_en;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.reg_a      = r_reg_a;
    assign bus.reg_d      = r_reg_d;
    assign bus.cond_sign  = r_cond_sign;
    assign bus.cond_carry = r_cond_carry;
    assign bus.cond_zero  = r_cond_zero;

endmodule
